// File: rtl/aes_inv_engine.sv
// aes_inv_engine: iterative AES-128/192/256 inverse cipher, one round per clock, key expanded once on load.
package aes_inv_pkg;
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction
    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] y, p;
        y = a;
        p = 8'h01;
        for (int i = 0; i < 7; i++) begin
            y = gmul(y, y);
            p = gmul(p, y);
        end
        return p;
    endfunction
    function automatic logic [7:0] rl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction
endpackage

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_inv_pkg::*;
    logic [7:0] v;
    assign v = ginv(a);
    assign y = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_inv_pkg::*;
    assign y = ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
endmodule

module aes_inv_engine #(
    parameter int KEY_WIDTH = 128,
    parameter int NR        = 10,
    parameter int NK        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    output logic                 key_ready,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         data_out,
    output logic                 busy
);
    import aes_inv_pkg::*;
    localparam int NW = 4 * (NR + 1);
    if (!((KEY_WIDTH == 128 && NR == 10 && NK == 4) || (KEY_WIDTH == 192 && NR == 12 && NK == 6) ||
          (KEY_WIDTH == 256 && NR == 14 && NK == 8))) begin : g_bad_params
        $fatal(1, "aes_inv_engine: unsupported KEY_WIDTH/NR/NK combination");
    end
    typedef enum logic [2:0] {NOKEY, EXPAND, READY, ROUND, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] w [NW];
    logic [5:0] wi;
    logic [2:0] kc;
    logic [7:0] rcon;
    logic [3:0] r, j;
    logic [127:0] st, rk, sr, sb, ak, mc;
    logic [31:0] prev, sub_in, sub_out, nw;
    logic key_acc, blk_acc;
    assign key_ready = state == NOKEY || state == READY;
    assign in_ready  = state == READY && !key_valid;
    assign out_valid = state == DONE;
    assign busy      = state == EXPAND || state == ROUND || state == DONE;
    assign key_acc   = key_valid && key_ready;
    assign blk_acc   = in_valid && in_ready;
    // kc tracks i mod NK so no divider is needed for the 192-bit schedule
    assign prev   = w[wi - 6'd1];
    assign sub_in = kc == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
    assign nw     = w[wi - 6'(NK)] ^ (kc == 3'd0 ? sub_out ^ {rcon, 24'h0} :
                                      (NK == 8 && kc == 3'd4) ? sub_out : prev);
    for (genvar k = 0; k < 4; k++) begin : g_ks
        aes_sbox u_sbox (.a(sub_in[8*k +: 8]), .y(sub_out[8*k +: 8]));
        assign rk[127-32*k -: 32] = w[{j, 2'b00} + 6'(k)];
    end
    assign j  = state == READY ? 4'(NR) : r;
    assign ak = sb ^ rk;
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar i = 0; i < 4; i++) begin : g_row
            assign sr[127-8*(4*c+i) -: 8] = st[127-8*(4*((c-i+4)%4)+i) -: 8];
            aes_inv_sbox u_isbox (.a(sr[127-8*(4*c+i) -: 8]), .y(sb[127-8*(4*c+i) -: 8]));
            assign mc[127-8*(4*c+i) -: 8] = gmul(ak[127-8*(4*c+i) -: 8], 8'h0e) ^
                                            gmul(ak[127-8*(4*c+(i+1)%4) -: 8], 8'h0b) ^
                                            gmul(ak[127-8*(4*c+(i+2)%4) -: 8], 8'h0d) ^
                                            gmul(ak[127-8*(4*c+(i+3)%4) -: 8], 8'h09);
        end
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            NOKEY:   state_nx = key_acc ? EXPAND : NOKEY;
            EXPAND:  state_nx = wi == 6'(NW - 1) ? READY : EXPAND;
            READY:   state_nx = key_acc ? EXPAND : blk_acc ? ROUND : READY;
            ROUND:   state_nx = r == 4'd0 ? DONE : ROUND;
            DONE:    state_nx = out_ready ? READY : DONE;
            default: state_nx = NOKEY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NOKEY;
            data_out <= '0;
        end else begin
            state <= state_nx;
            if (state == ROUND && r == 4'd0) data_out <= ak;
        end
    end
    always_ff @(posedge clk) begin
        if (key_acc) begin
            for (int k = 0; k < NK; k++) w[k] <= key[KEY_WIDTH-1-32*k -: 32];
            wi   <= 6'(NK);
            kc   <= 3'd0;
            rcon <= 8'h01;
        end else if (state == EXPAND) begin
            w[wi] <= nw;
            wi    <= wi + 6'd1;
            kc    <= kc == 3'(NK - 1) ? 3'd0 : kc + 3'd1;
            if (kc == 3'd0) rcon <= xt(rcon);
        end
        if (blk_acc) begin
            st <= data_in ^ rk;
            r  <= 4'(NR - 1);
        end else if (state == ROUND) begin
            st <= r == 4'd0 ? ak : mc;
            r  <= r - 4'd1;
        end
    end
endmodule

// File: tb/tb_aes_inv_engine.sv
// tb_aes_inv_engine: runs 128/192/256-bit engines side by side against a forward-cipher reference model.
module tb_aes_inv_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic [7:0] sbt [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic chk(input string nm, input int g, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s kw=%0d act=%h exp=%h", nm, 128 + 64 * g, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input int g);
        total++;
        bad++;
        $display("FAIL %s kw=%0d act=event exp=none", nm, 128 + 64 * g);
    endtask

    // S-box built from log/antilog tables over generator 3, then the affine map
    initial begin
        logic [7:0] alog [256];
        int lg [256];
        logic [7:0] t, v, s;
        t = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog[i] = t;
            lg[t] = i;
            t = t ^ xt(t);
        end
        for (int x = 0; x < 256; x++) begin
            v = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
            s = 8'h63;
            for (int b = 0; b < 8; b++)
                s[b] = s[b] ^ v[b] ^ v[(b+4)%8] ^ v[(b+5)%8] ^ v[(b+6)%8] ^ v[(b+7)%8];
            sbt[x] = s;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [255:0] kal, input int nk, input logic [127:0] pt);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] s [16], u [16], a [4], rc;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = kal[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int n = 0; n < 16; n++) u[n] = sbt[s[n]];
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++) s[4*c+i] = u[4*((c+i)%4)+i];
            if (rnd != nr)
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) a[i] = s[4*c+i];
                    for (int i = 0; i < 4; i++)
                        s[4*c+i] = xt(a[i]) ^ xt(a[(i+1)%4]) ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
                end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*rnd+n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int KW = 128 + 64 * g;
        localparam int NR = 10 + 2 * g;
        localparam int NK = 4 + 2 * g;
        localparam logic [127:0] FCT = (g == 0) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
                                       (g == 1) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                                  128'h8ea2b7ca516745bfeafc49904b496089;
        localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
        logic rst = 1'b1, key_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0, hold = 1'b0;
        logic key_ready, in_ready, out_valid, busy;
        logic [255:0] kb = '0, cur = '0, fk;
        logic [127:0] din = '0, dout;
        logic [127:0] q [$];
        int lq [$];
        bit fin = 1'b0;

        aes_inv_engine #(.KEY_WIDTH(KW), .NR(NR), .NK(NK)) dut (
            .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(kb[255 -: KW]),
            .in_valid(in_valid), .in_ready(in_ready), .data_in(din), .out_valid(out_valid),
            .out_ready(out_ready), .data_out(dout), .busy(busy)
        );

        initial forever begin
            @(posedge clk);
            #2 out_ready = !hold && ($urandom % 4 != 0);
        end

        initial begin
            bit pov;
            int lat;
            pov = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) pov = 1'b0;
                else begin
                    if (out_valid && !pov) begin
                        if (lq.size() == 0) fail_now("unexpected_valid", g);
                        else begin
                            lat = cyc - lq.pop_front();
                            chk("latency", g, 128'(lat), 128'(NR));
                        end
                    end
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) fail_now("unexpected_out", g);
                        else chk("plaintext", g, dout, q.pop_front());
                    end
                    pov = out_valid;
                end
            end
        end

        task automatic do_key(input logic [255:0] k);
            int n;
            @(negedge clk);
            key_valid = 1'b1;
            kb = k;
            n = 0;
            #1;
            while (!key_ready && n < 500) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (n >= 500) begin
                fail_now("key_timeout", g);
                key_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1 key_valid = 1'b0;
            cur = k;
            n = 0;
            @(negedge clk);
            while (busy && n < 200) begin
                n++;
                @(negedge clk);
            end
            chk("expand_len", g, 128'(n), 128'(4 * (NR + 1) - NK));
        endtask

        task automatic do_blk(input logic [127:0] ct, input logic [127:0] pt);
            int n;
            @(negedge clk);
            in_valid = 1'b1;
            din = ct;
            n = 0;
            #1;
            while (!in_ready && n < 500) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (n >= 500) begin
                fail_now("blk_timeout", g);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            q.push_back(pt);
            lq.push_back(cyc);
        endtask

        task automatic rand_blks(input int cnt);
            logic [127:0] pt;
            for (int i = 0; i < cnt; i++) begin
                pt = rnd128();
                do_blk(aes_enc(cur, NK, pt), pt);
            end
        endtask

        task automatic drain();
            int n;
            n = 0;
            while ((q.size() != 0 || out_valid) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 2000) fail_now("drain_timeout", g);
        endtask

        initial begin
            logic [127:0] pt;
            logic [255:0] k2;
            int n;
            for (int i = 0; i < 32; i++) fk[255-8*i -: 8] = 8'(i);
            repeat (3) @(negedge clk);
            chk("rst_key_ready", g, 128'(key_ready), 128'd1);
            chk("rst_in_ready", g, 128'(in_ready), 128'd0);
            chk("rst_out_valid", g, 128'(out_valid), 128'd0);
            chk("rst_data_out", g, dout, 128'd0);
            chk("rst_busy", g, 128'(busy), 128'd0);
            rst = 1'b0;
            do_key(fk);
            do_blk(FCT, FPT);
            drain();
            k2 = 256'h1 << (256 - KW);
            do_key(k2);
            do_blk(aes_enc(k2, NK, 128'h1), 128'h1);
            drain();
            rand_blks(12);
            drain();
            // hold the result in DONE and watch it stay put
            hold = 1'b1;
            pt = rnd128();
            do_blk(aes_enc(cur, NK, pt), pt);
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) fail_now("done_timeout", g);
            for (int i = 0; i < 5; i++) begin
                chk("bp_data_stable", g, dout, pt);
                chk("bp_in_ready", g, 128'(in_ready), 128'd0);
                chk("bp_key_ready", g, 128'(key_ready), 128'd0);
                @(negedge clk);
            end
            hold = 1'b0;
            drain();
            // key and block offered together: the key must win
            for (int i = 0; i < 8; i++) k2[32*i +: 32] = $urandom();
            @(negedge clk);
            key_valid = 1'b1;
            kb = k2;
            in_valid = 1'b1;
            din = rnd128();
            #1;
            chk("prio_in_ready", g, 128'(in_ready), 128'd0);
            chk("prio_key_ready", g, 128'(key_ready), 128'd1);
            @(posedge clk);
            #1 key_valid = 1'b0;
            in_valid = 1'b0;
            cur = k2;
            @(negedge clk);
            chk("prio_busy", g, 128'(busy), 128'd1);
            n = 0;
            while (!key_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            rand_blks(4);
            drain();
            // reset while the round counter is at 4
            pt = rnd128();
            do_blk(aes_enc(cur, NK, pt), pt);
            repeat (NR - 5) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("midrst_out_valid", g, 128'(out_valid), 128'd0);
            chk("midrst_key_ready", g, 128'(key_ready), 128'd1);
            chk("midrst_in_ready", g, 128'(in_ready), 128'd0);
            q.delete();
            lq.delete();
            @(negedge clk);
            rst = 1'b0;
            in_valid = 1'b1;
            din = FCT;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (i % 5 == 0) chk("nokey_in_ready", g, 128'(in_ready), 128'd0);
            end
            in_valid = 1'b0;
            do_key(fk);
            do_blk(FCT, FPT);
            drain();
            fin = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(u[0].fin && u[1].fin && u[2].fin) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60000) begin
            total++;
            bad++;
            $display("FAIL global_timeout act=%0d exp=<60000", n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
